// File: rtl/acc_display_driver.sv
// Accumulator display driver: sequential double-dabble binary-to-BCD conversion
// feeding a 3-digit, active-low, time-multiplexed seven-segment display.
module acc_display_driver #(
  parameter int unsigned REFRESH_DIV   = 4000,
  parameter bit          BLANK_LEADING = 1'b1
) (
  input  logic       clock,
  input  logic       resetN,
  input  logic [7:0] value,
  output logic [7:0] SevenSegment,
  output logic [2:0] Enable,
  output logic       busy
);

  localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_LOAD
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       last_value_q, last_value_d;
  // [19:8] = BCD hundreds/tens/ones, [7:0] = binary operand
  logic [19:0]      conv_q, conv_d;
  logic [19:0]      conv_adj;
  logic [2:0]       shift_count_q, shift_count_d;
  logic [3:0]       hund_q, hund_d;
  logic [3:0]       tens_q, tens_d;
  logic [3:0]       ones_q, ones_d;
  logic [CNT_W-1:0] refresh_q, refresh_d;
  logic [1:0]       digit_idx_q, digit_idx_d;
  logic [7:0]       seg_q, seg_d;
  logic [2:0]       en_q, en_d;

  function automatic logic [7:0] seg_code(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'h03;
      4'd1:    s = 8'h9F;
      4'd2:    s = 8'h25;
      4'd3:    s = 8'h0D;
      4'd4:    s = 8'h99;
      4'd5:    s = 8'h49;
      4'd6:    s = 8'h41;
      4'd7:    s = 8'h1F;
      4'd8:    s = 8'h01;
      4'd9:    s = 8'h09;
      default: s = 8'hFF;
    endcase
    return s;
  endfunction

  always_comb begin
    conv_adj = conv_q;
    for (int unsigned i = 0; i < 3; i++) begin
      if (conv_q[8+4*i +: 4] >= 4'd5) begin
        conv_adj[8+4*i +: 4] = conv_q[8+4*i +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    last_value_d  = last_value_q;
    conv_d        = conv_q;
    shift_count_d = shift_count_q;
    hund_d        = hund_q;
    tens_d        = tens_q;
    ones_d        = ones_q;
    case (state_q)
      ST_IDLE: begin
        if (value != last_value_q) begin
          last_value_d  = value;
          conv_d        = {12'd0, value};
          shift_count_d = '0;
          state_d       = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        conv_d        = conv_adj << 1;
        shift_count_d = shift_count_q + 3'd1;
        if (shift_count_q == 3'd7) begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        hund_d  = conv_q[19:16];
        tens_d  = conv_q[15:12];
        ones_d  = conv_q[11:8];
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    refresh_d   = refresh_q + 1'b1;
    digit_idx_d = digit_idx_q;
    if (refresh_q == CNT_MAX) begin
      refresh_d   = '0;
      digit_idx_d = (digit_idx_q == 2'd2) ? 2'd0 : digit_idx_q + 2'd1;
    end
  end

  // Outputs are registered from the current index/digits, so any change shows one edge later.
  always_comb begin
    seg_d = 8'hFF;
    en_d  = 3'b111;
    case (digit_idx_q)
      2'd0: begin
        en_d  = 3'b011;
        seg_d = seg_code(ones_q);
      end
      2'd1: begin
        en_d  = 3'b101;
        seg_d = (BLANK_LEADING && hund_q == 4'd0 && tens_q == 4'd0) ? 8'hFF : seg_code(tens_q);
      end
      2'd2: begin
        en_d  = 3'b110;
        seg_d = (BLANK_LEADING && hund_q == 4'd0) ? 8'hFF : seg_code(hund_q);
      end
      default: begin
        seg_d = 8'hFF;
        en_d  = 3'b111;
      end
    endcase
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q       <= ST_IDLE;
      last_value_q  <= '0;
      conv_q        <= '0;
      shift_count_q <= '0;
      hund_q        <= '0;
      tens_q        <= '0;
      ones_q        <= '0;
      refresh_q     <= '0;
      digit_idx_q   <= '0;
      seg_q         <= '1;
      en_q          <= '1;
    end else begin
      state_q       <= state_d;
      last_value_q  <= last_value_d;
      conv_q        <= conv_d;
      shift_count_q <= shift_count_d;
      hund_q        <= hund_d;
      tens_q        <= tens_d;
      ones_q        <= ones_d;
      refresh_q     <= refresh_d;
      digit_idx_q   <= digit_idx_d;
      seg_q         <= seg_d;
      en_q          <= en_d;
    end
  end

  assign SevenSegment = seg_q;
  assign Enable       = en_q;
  assign busy         = (state_q != ST_IDLE);

endmodule

// File: doc/acc_display_driver.md
# acc_display_driver

Downstream display stage for the soft CPU: consumes the 8-bit accumulator and drives the board's 3-digit, active-low, multiplexed seven-segment display in unsigned decimal (000–255). The driver replaces the wrapper's constant blanking of `SevenSegment`/`Enable`. It converts each new accumulator value with a sequential double-dabble engine, holds the BCD result, and time-multiplexes the three digits with a refresh divider.

## Interface
- `REFRESH_DIV`, default 4000: clock cycles each digit stays enabled. 12 MHz / 4000 = 3 kHz digit rate.
- `BLANK_LEADING`, default 1: 1 blanks leading zeros in the hundreds and tens digits; 0 shows all three digits.
- `clock`  in  1  single system clock; all state changes on the rising edge.
- `resetN`  in  1  asynchronous, active-low reset.
- `value`  in  8  unsigned accumulator value (ACC).
- `SevenSegment`  out  8  active-low segments. Bit7=a, bit6=b, bit5=c, bit4=d, bit3=e, bit2=f, bit1=g, bit0=dp.
- `Enable`  out  3  active-low digit enables. Enable[0]=hundreds, Enable[1]=tens, Enable[2]=ones.
- `busy`  out  1  high while a conversion is in progress.

## Operation
- Registers:
  - `lastValue[7:0]`: last captured value.
  - Conversion shift register: 8 binary bits plus 12 BCD bits.
  - `shiftCount[2:0]`.
  - Display digits `hund`, `tens`, `ones` (4 bits each).
  - Refresh counter.
  - `digitIdx[1:0]`.
- FSM states: IDLE, SHIFT, LOAD.
- IDLE: if `value != lastValue`, capture `value` into the binary field and into `lastValue`, clear the BCD field and `shiftCount`, and go to SHIFT. Otherwise stay in IDLE.
- SHIFT, one double-dabble step per cycle:
  - Add 3 to every BCD nibble ≥ 5.
  - Shift the whole register left by 1.
  - After the 8th shift (`shiftCount` = 7), go to LOAD.
- LOAD: copy the BCD nibbles to `hund`/`tens`/`ones`, then go to IDLE.
- `busy` = (state != IDLE).
- Changes to `value` during SHIFT/LOAD are ignored. Because `lastValue` holds the captured value, a differing `value` is picked up in the first IDLE cycle after LOAD, starting a new conversion. Intermediate values that revert before IDLE are never shown.
- Refresh:
  - The counter runs 0..REFRESH_DIV-1 and wraps.
  - On each wrap, `digitIdx` advances 0→1→2→0. 3 is never reached.
  - Index 0 = ones (`Enable`=3'b011), 1 = tens (3'b101), 2 = hundreds (3'b110).
- Segment codes, active low, dp always off: 0=0x03, 1=0x9F, 2=0x25, 3=0x0D, 4=0x99, 5=0x49, 6=0x41, 7=0x1F, 8=0x01, 9=0x09. Blank = 0xFF.
- Blanking when BLANK_LEADING=1:
  - Hundreds blanks if `hund`=0.
  - Tens blanks if `hund`=0 and `tens`=0.
  - Ones is never blanked.
  - A blanked digit keeps its `Enable` asserted and drives 0xFF.
- BCD nibbles > 9 cannot occur for 8-bit input. If one appears, the decoder outputs 0xFF.

## Timing
- During reset, all state is cleared asynchronously:
  - FSM=IDLE, `lastValue`=0, digits=0, refresh counter=0, `digitIdx`=0.
  - Outputs: `SevenSegment`=8'hFF, `Enable`=3'b111, `busy`=0.
- `SevenSegment` and `Enable` are registered from `digitIdx` and the digit registers. They take effect one edge after either changes.
- First edge after `resetN` rises: `Enable`=3'b011, `SevenSegment`=0x03. The display shows "0", since `value`=0 matches `lastValue`.
- Conversion latency, with edge E0 the first edge sampling a new `value` in IDLE:
  - Capture at E0.
  - Shifts at E1–E8.
  - Digit registers load at E9.
  - Segment outputs reflect the new digit at E10.
  - `busy` is high after E0 through E9 (9 cycles) and low after E9.
- Back-to-back: the earliest restart is E10, i.e. one IDLE cycle between conversions.
- Reset asserted mid-conversion aborts immediately. The display returns to "0" after release; no partial result is ever loaded.
- Conversion and refresh are independent. A digit load coinciding with a refresh wrap is legal: the next output edge uses the new index and the new digits.

## Test plan
- Reset and release with `value`=0:
  - Outputs are 0xFF/3'b111 during reset.
  - After release, `Enable` cycles 011/101/110 with segments 0x03/0xFF/0xFF.
  - `busy` stays 0.
- `value`=42 (REFRESH_DIV=4 in sim):
  - `busy` is high for exactly 9 cycles.
  - Then ones=0x25, tens=0x99, hundreds=0xFF.
  - Each `Enable` pattern holds 4 cycles.
- `value`=255 → hundreds 0x25, tens 0x49, ones 0x49.
- `value`=100 → hundreds 0x9F, tens 0x03 (not blanked), ones 0x03.
- `value`=5 with BLANK_LEADING=0 → hundreds 0x03, tens 0x03, ones 0x49.
- Mid-operation events:
  - `value`=42 at E0, changed to 7 at E3: 42 loads at E9, a second conversion starts at E10, and the ones digit becomes 0x1F after E20 with tens/hundreds blanked.
  - Separately, assert `resetN`=0 at E4: outputs go to 0xFF/3'b111 at once with `busy`=0, and the display shows "0" after release.
